// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM responder: word-organised memory with programmable wait states,
// byte/halfword/word write lanes and two-cycle ERROR responses.
`timescale 1ns/1ps
module ahb_ram_slave #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [2:0]  dbg_state
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);

  // Handshake: a transfer is accepted on a rising edge where HSEL & HREADY &
  // HTRANS[1] and the FSM can start a transfer; it completes on the first
  // data-phase edge where HREADYOUT=1.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t         state, state_nxt, start_state;
  logic [3:0]     cnt, cnt_nxt;
  logic [31:0]    addr_q;
  logic           write_q;
  logic [2:0]     size_q;
  logic [31:0]    mem [MEM_WORDS];

  logic           can_accept, accept, in_range, misalign, err_in;
  logic [31:0]    off_in, off_q;
  logic [AW-1:0]  idx;
  logic [3:0]     be;
  logic           unused_ok;

  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = HSEL && HREADY && HTRANS[1] && can_accept;

  // Range check relies on BASE_ADDR being aligned to the memory size.
  assign off_in   = HADDR - BASE_ADDR;
  assign in_range = (HADDR >= BASE_ADDR) && ({1'b0, off_in} < MEM_BYTES);
  assign misalign = ((HSIZE == 3'd1) && HADDR[0]) ||
                    ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign err_in   = !in_range || (HSIZE > 3'd2) || misalign;

  always_comb begin
    start_state = ST_IDLE;
    if (accept) begin
      if (err_in)          start_state = ST_ERR1;
      else if (WS != 4'd0) start_state = ST_WAIT;
      else                 start_state = ST_DATA;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = 4'd0;
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    case (state)
      ST_IDLE, ST_DATA: state_nxt = start_state;
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt + 4'd1 == WS) state_nxt = ST_DATA;
        else                  cnt_nxt   = cnt + 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = 2'b01;
        state_nxt = start_state;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  assign off_q = addr_q - BASE_ADDR;
  assign idx   = off_q[AW+1:2];

  always_comb begin
    be = 4'b0000;
    case (size_q[1:0])
      2'd0:    be[addr_q[1:0]] = 1'b1;
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Reset leaves the array alone; an abandoned write never reaches DATA.
  always_ff @(posedge CLK) begin
    if (state == ST_DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA    = (state == ST_DATA) ? mem[idx] : 32'd0;
  assign dbg_state = state;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], off_q, size_q[2]};

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: three instances with 3, 1 and 0 wait
// states share the bus; a vector table plus hand-written pipelining/error/reset sequences.
`timescale 1ns/1ps
module tb_ahb_ram_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       hsel;
  logic [31:0]      haddr, hwdata;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic             hready;
  logic [1:0]       cur;
  logic [2:0]       hro;
  logic [2:0][1:0]  hrs;
  logic [2:0][31:0] hrd;
  logic [2:0][2:0]  dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign hready = (cur == 2'd2) ? hro[2] : (cur == 2'd1) ? hro[1] : hro[0];

  ahb_ram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
    .CLK(clk), .RST(rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hro[0]),
    .HRESP(hrs[0]), .HRDATA(hrd[0]), .dbg_state(dbg[0]));

  ahb_ram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_ws1 (
    .CLK(clk), .RST(rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HPROT(4'b0011),
    .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hro[1]),
    .HRESP(hrs[1]), .HRDATA(hrd[1]), .dbg_state(dbg[1]));

  ahb_ram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RST(rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011),
    .HMASTLOCK(1'b0), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hro[2]),
    .HRESP(hrs[2]), .HRDATA(hrd[2]), .dbg_state(dbg[2]));

  typedef struct {
    logic [1:0]  d;
    logic        w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [1:0]  resp;
    logic [31:0] exp_rd;
    logic        chk_rd;
    int          cyc;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated transfer; returns first/last data-phase HRESP, final HRDATA, cycle count.
  task automatic xfer(input logic [1:0] d, input logic w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [1:0] r_first, output logic [1:0] r_last,
                      output logic [31:0] rd, output int cyc);
    logic done;
    cur    = d;
    hsel   = 3'b001 << d;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    step;
    hsel    = 3'b000;
    htrans  = 2'b00;
    hwdata  = wd;
    r_first = hrs[d];
    cyc     = 0;
    done    = 1'b0;
    while (!done) begin
      cyc++;
      if (hro[d]) begin
        done = 1'b1;
      end else begin
        chk("wait_hrdata_zero", hrd[d], 32'd0);
        if (cyc >= 40) begin
          checks++;
          errors++;
          $display("FAIL xfer_timeout: HREADYOUT still %b after %0d cycles, required 1", hro[d], cyc);
          done = 1'b1;
        end else begin
          step;
        end
      end
    end
    r_last = hrs[d];
    rd     = hrd[d];
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rf, rl;
    logic [31:0] rd;
    int          cyc;

    tbl[0]  = '{2'd1, 1'b1, BASE + 32'h4,   3'd2, 32'hDEAD_BEEF, 2'b00, 32'h0,         1'b0, 2};
    tbl[1]  = '{2'd1, 1'b0, BASE + 32'h4,   3'd2, 32'h0,         2'b00, 32'hDEAD_BEEF, 1'b1, 2};
    tbl[2]  = '{2'd1, 1'b1, BASE + 32'h0,   3'd2, 32'h0,         2'b00, 32'h0,         1'b0, 2};
    tbl[3]  = '{2'd1, 1'b1, BASE + 32'h1,   3'd0, 32'h7766_AA55, 2'b00, 32'h0,         1'b0, 2};
    tbl[4]  = '{2'd1, 1'b1, BASE + 32'h2,   3'd1, 32'h1234_9999, 2'b00, 32'h0,         1'b0, 2};
    tbl[5]  = '{2'd1, 1'b0, BASE + 32'h0,   3'd2, 32'h0,         2'b00, 32'h1234_AA00, 1'b1, 2};
    tbl[6]  = '{2'd1, 1'b0, BASE + 32'h100, 3'd2, 32'h0,         2'b01, 32'h0,         1'b1, 2};
    tbl[7]  = '{2'd1, 1'b1, BASE + 32'h2,   3'd2, 32'hFFFF_FFFF, 2'b01, 32'h0,         1'b0, 2};
    tbl[8]  = '{2'd1, 1'b0, BASE + 32'h0,   3'd2, 32'h0,         2'b00, 32'h1234_AA00, 1'b1, 2};
    tbl[9]  = '{2'd1, 1'b1, BASE + 32'h1,   3'd1, 32'hFFFF_FFFF, 2'b01, 32'h0,         1'b0, 2};
    tbl[10] = '{2'd1, 1'b0, BASE + 32'h0,   3'd3, 32'h0,         2'b01, 32'h0,         1'b1, 2};
    tbl[11] = '{2'd1, 1'b0, BASE - 32'h4,   3'd2, 32'h0,         2'b01, 32'h0,         1'b1, 2};
    tbl[12] = '{2'd1, 1'b0, BASE + 32'h0,   3'd2, 32'h0,         2'b00, 32'h1234_AA00, 1'b1, 2};
    tbl[13] = '{2'd1, 1'b0, BASE + 32'h3,   3'd0, 32'h0,         2'b00, 32'h1234_AA00, 1'b1, 2};
    tbl[14] = '{2'd0, 1'b1, BASE + 32'hC,   3'd2, 32'h0BAD_CAFE, 2'b00, 32'h0,         1'b0, 4};
    tbl[15] = '{2'd0, 1'b0, BASE + 32'hC,   3'd2, 32'h0,         2'b00, 32'h0BAD_CAFE, 1'b1, 4};
    tbl[16] = '{2'd2, 1'b1, BASE + 32'h10,  3'd2, 32'hA5A5_5A5A, 2'b00, 32'h0,         1'b0, 1};
    tbl[17] = '{2'd2, 1'b0, BASE + 32'h10,  3'd2, 32'h0,         2'b00, 32'hA5A5_5A5A, 1'b1, 1};
    tbl[18] = '{2'd2, 1'b1, BASE + 32'h12,  3'd1, 32'hBEEF_0000, 2'b00, 32'h0,         1'b0, 1};
    tbl[19] = '{2'd2, 1'b0, BASE + 32'h10,  3'd2, 32'h0,         2'b00, 32'hBEEF_5A5A, 1'b1, 1};
    tbl[20] = '{2'd1, 1'b1, BASE + 32'hFC,  3'd2, 32'hFCFC_0001, 2'b00, 32'h0,         1'b0, 2};
    tbl[21] = '{2'd1, 1'b0, BASE + 32'hFC,  3'd2, 32'h0,         2'b00, 32'hFCFC_0001, 1'b1, 2};

    rst = 1'b1; cur = 2'd0; hsel = 3'b000; haddr = 32'd0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_hreadyout_%0d", k), 32'(hro[k]), 32'd1);
      chk($sformatf("reset_hresp_%0d", k),     32'(hrs[k]), 32'd0);
      chk($sformatf("reset_hrdata_%0d", k),    hrd[k],      32'd0);
      chk($sformatf("reset_state_%0d", k),     32'(dbg[k]), 32'd0);
    end
    rst = 1'b0;
    step;

    for (int i = 0; i < NV; i++) begin
      xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, rf, rl, rd, cyc);
      chk($sformatf("v%0d_resp_first", i), 32'(rf),  32'(tbl[i].resp));
      chk($sformatf("v%0d_resp_last", i),  32'(rl),  32'(tbl[i].resp));
      chk($sformatf("v%0d_cycles", i),     32'(cyc), 32'(tbl[i].cyc));
      if (tbl[i].chk_rd) chk($sformatf("v%0d_hrdata", i), rd, tbl[i].exp_rd);
    end

    // Pipelined write then read on the zero-wait instance.
    xfer(2'd2, 1'b1, BASE + 32'h14, 3'd2, 32'h0, rf, rl, rd, cyc);
    cur = 2'd2; hsel = 3'b100; htrans = 2'b10; haddr = BASE + 32'h14; hwrite = 1'b1; hsize = 3'd2;
    step;
    hwdata = 32'h1111_1111; hwrite = 1'b0;
    chk("pipe_write_ready", 32'(hro[2]), 32'd1);
    step;
    hsel = 3'b000; htrans = 2'b00;
    chk("pipe_read_ready",  32'(hro[2]), 32'd1);
    chk("pipe_read_resp",   32'(hrs[2]), 32'd0);
    chk("pipe_read_hrdata", hrd[2],      32'h1111_1111);
    step;
    chk("pipe_back_idle",   32'(dbg[2]), 32'd0);

    // Error response with the next transfer accepted during ERR2.
    cur = 2'd1; hsel = 3'b010; htrans = 2'b10; haddr = BASE + 32'h100; hwrite = 1'b0; hsize = 3'd2;
    step;
    haddr = BASE + 32'h4;
    chk("err1_ready", 32'(hro[1]), 32'd0);
    chk("err1_resp",  32'(hrs[1]), 32'd1);
    step;
    chk("err2_ready", 32'(hro[1]), 32'd1);
    chk("err2_resp",  32'(hrs[1]), 32'd1);
    step;
    hsel = 3'b000; htrans = 2'b00;
    chk("after_err_wait_ready", 32'(hro[1]), 32'd0);
    chk("after_err_wait_resp",  32'(hrs[1]), 32'd0);
    step;
    chk("after_err_data_ready",  32'(hro[1]), 32'd1);
    chk("after_err_data_resp",   32'(hrs[1]), 32'd0);
    chk("after_err_data_hrdata", hrd[1],      32'hDEAD_BEEF);
    step;

    // BUSY with HSEL=1, then NONSEQ with HSEL=0: neither is a transfer.
    xfer(2'd2, 1'b1, BASE + 32'h18, 3'd2, 32'h2424_2424, rf, rl, rd, cyc);
    cur = 2'd2; hsel = 3'b100; htrans = 2'b01; hwrite = 1'b1; haddr = BASE + 32'h18;
    hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
    for (int j = 0; j < 4; j++) begin
      if (j == 2) begin
        hsel = 3'b000; htrans = 2'b10;
      end
      step;
      chk($sformatf("nosel_ready_%0d", j), 32'(hro[2]), 32'd1);
      chk($sformatf("nosel_resp_%0d", j),  32'(hrs[2]), 32'd0);
    end
    htrans = 2'b00;
    xfer(2'd2, 1'b0, BASE + 32'h18, 3'd2, 32'h0, rf, rl, rd, cyc);
    chk("nosel_mem_unchanged", rd, 32'h2424_2424);

    // Reset asserted during WAIT abandons the write.
    xfer(2'd0, 1'b1, BASE + 32'h8, 3'd2, 32'h5555_AAAA, rf, rl, rd, cyc);
    cur = 2'd0; hsel = 3'b001; htrans = 2'b10; haddr = BASE + 32'h8; hwrite = 1'b1; hsize = 3'd2;
    step;
    hsel = 3'b000; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    chk("rst_pre_wait_ready", 32'(hro[0]), 32'd0);
    step;
    rst = 1'b1;
    #1;
    chk("rst_async_ready",  32'(hro[0]), 32'd1);
    chk("rst_async_resp",   32'(hrs[0]), 32'd0);
    chk("rst_async_hrdata", hrd[0],      32'd0);
    chk("rst_async_state",  32'(dbg[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step;
    xfer(2'd0, 1'b0, BASE + 32'h8, 3'd2, 32'h0, rf, rl, rd, cyc);
    chk("rst_write_abandoned", rd,        32'h5555_AAAA);
    chk("rst_read_cycles",     32'(cyc),  32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
- AHB-Lite responder: a word-organised RAM behind the ahb_s modport signal set of ahb_if.
- Sits on the bus/interconnect side, opposite the core's AHB master, and serves as on-chip memory and verification target.
- Handles address/data phase pipelining, programmable wait states, byte/halfword/word writes and two-cycle ERROR responses.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*4.
- WAIT_STATES, 1, HREADYOUT-low cycles inserted in every OKAY NONSEQ/SEQ data phase; range 0..15.

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size: 0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  burst type; ignored, every beat is handled independently.
- HPROT  in  4  protection attributes; ignored.
- HMASTLOCK  in  1  locked transfer; ignored.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; an address phase is accepted only when HREADY=1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  response: 00 OKAY, 01 ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset (RST=1, asynchronous) forces:
  - HREADYOUT=1, HRESP=00, HRDATA=0;
  - FSM=IDLE, wait counter=0, all latched address-phase fields cleared.
  - Memory contents are not reset.
  - A transfer in flight is abandoned; a write that has not reached its final data-phase cycle is not committed.
- Accept: when HSEL & HREADY & HTRANS[1], latch HADDR, HWRITE, HSIZE on the edge; the next cycle is that transfer's data phase.
- Non-accepted cycles: IDLE/BUSY transfers, or HSEL=0, get a zero-wait OKAY (HREADYOUT=1, HRESP=00) in the following cycle.
- Error check, evaluated at accept. Any one of the following makes the transfer an error:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4);
  - HSIZE>2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]!=00.
- FSM states:
  - IDLE: no pending data phase. HREADYOUT=1, HRESP=00.
    - Accept, OK, WAIT_STATES>0 -> WAIT.
    - Accept, OK, WAIT_STATES=0 -> DATA.
    - Accept, error -> ERR1.
  - WAIT: HREADYOUT=0, HRESP=00; counter counts 1..WAIT_STATES, then -> DATA.
  - DATA: HREADYOUT=1, HRESP=00; the transfer completes this cycle.
    - Write: commit HWDATA lanes at the end of the cycle.
    - Read: HRDATA is valid this cycle.
    - An accept in this same cycle is legal (pipelined); the next state is chosen as from IDLE, otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=01; -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Memory is untouched. An accept here is honoured as from IDLE, otherwise -> IDLE.
- Byte lanes on write, per little-endian HADDR[1:0]:
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
  - Unselected bytes keep their old value.
- Read data:
  - In DATA, HRDATA is the full 32-bit word at the latched address, read combinationally from the array.
  - A write committed at the end of cycle N is visible to a read whose DATA cycle is N+1 or later.
  - HRDATA=0 in every state other than DATA.
- Word index = (latched HADDR - BASE_ADDR)[log2(MEM_WORDS)+1:2]; no wrap-around, since out-of-range addresses are errors.
- HREADY=0 while in IDLE: another slave owns the data phase; no accept occurs.

Test Plan:
- Reset mid-transfer: start a word write of 32'hCAFE_F00D to BASE_ADDR+8 with WAIT_STATES=3, assert RST during WAIT -> HREADYOUT=1, HRESP=00, HRDATA=0 immediately; a later read of BASE_ADDR+8 returns the prior contents.
- Word write then read, WAIT_STATES=1: write 32'hDEAD_BEEF to BASE_ADDR+4, then read BASE_ADDR+4 -> each data phase is 2 cycles (HREADYOUT 0 then 1); the read's final cycle shows HRDATA=32'hDEAD_BEEF, HRESP=00.
- Byte/halfword lanes: word-write 0, byte-write 8'hAA to +1, halfword-write 16'h1234 to +2, read the word -> 32'h1234_AA00.
- Back-to-back pipelined transfers, WAIT_STATES=0: NONSEQ write 32'h1111_1111 to +0, NONSEQ read of +0 in the write's data-phase cycle -> HREADYOUT stays 1; the read returns 32'h1111_1111 in the next cycle.
- Error response: word read at BASE_ADDR+MEM_WORDS*4, then a separate word write at +2 (misaligned) -> each gives HRESP=01 with HREADYOUT=0 then HRESP=01 with HREADYOUT=1; memory unchanged; a following NONSEQ accepted in ERR2 completes as OKAY.
- IDLE/BUSY/HSEL=0: HTRANS=01 with HSEL=1, and HTRANS=10 with HSEL=0 -> no memory change; HREADYOUT=1 and HRESP=00 every cycle.
